// File: rtl/uart_tx_arbiter_if.sv
// Requester side (req/pkt_data/ack/gnt_id/busy) and UART side (trmt/tx_data/tx_done)
// of the shared-transmitter arbiter, bundled as one interface.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int BYTES   = 2
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*8*BYTES-1:0] pkt_data;
   logic [NUM_REQ-1:0]         ack;
   logic [IDW-1:0]             gnt_id;
   logic                       busy;
   logic                       trmt;
   logic [7:0]                 tx_data;
   logic                       tx_done;

   modport slave (
      input  req, pkt_data, tx_done,
      output ack, gnt_id, busy, trmt, tx_data
   );

   modport master (
      output req, pkt_data, tx_done,
      input  ack, gnt_id, busy, trmt, tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters;
// each grant sends a BYTES-byte packet MSB byte first, then pulses ack for one cycle.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int BYTES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = 8 * BYTES;
   localparam int CW  = $clog2(BYTES) + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      pkt_q, pkt_d;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
   logic [7:0]         tx_data_q, tx_data_d;

   logic [IDW-1:0]     win_id;
   logic               win_vld;
   logic [PW-1:0]      win_pkt;
   logic [PW-1:0]      pkt_arr [NUM_REQ];
   logic [NUM_REQ-1:0] gnt_hit;
   logic [NUM_REQ-1:0] ack_c;
   logic               trmt_c;
   logic               busy_c;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign pkt_arr[gi] = bus.pkt_data[gi*PW +: PW];
         assign gnt_hit[gi] = (gnt_id_q == IDW'(gi));
      end
   endgenerate

   // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      logic [IDW:0] cand;
      cand    = '0;
      win_id  = '0;
      win_vld = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NUM_REQ)) begin
            cand = cand - (IDW+1)'(NUM_REQ);
         end
         if (bus.req[cand[IDW-1:0]]) begin
            win_id  = cand[IDW-1:0];
            win_vld = 1'b1;
         end
      end
   end

   assign win_pkt = pkt_arr[win_id];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // tx_done is deliberately not looked at in SEND: it may still be high from the last byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_vld) state_d = SEND;
         SEND:    state_d = WAIT;
         WAIT:    if (bus.tx_done) state_d = (byte_cnt_q == '0) ? DONE : SEND;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      trmt_c = (state_q == SEND);
      busy_c = (state_q != IDLE);
      ack_c  = (state_q == DONE) ? gnt_hit : '0;
   end

   always_comb begin
      pkt_d      = pkt_q;
      gnt_id_d   = gnt_id_q;
      rr_ptr_d   = rr_ptr_q;
      byte_cnt_d = byte_cnt_q;
      tx_data_d  = tx_data_q;
      if (state_q == IDLE && win_vld) begin
         pkt_d      = win_pkt;
         gnt_id_d   = win_id;
         rr_ptr_d   = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
         byte_cnt_d = CW'(BYTES - 1);
         tx_data_d  = win_pkt[PW-1 -: 8];
      end else if (state_q == WAIT && bus.tx_done && byte_cnt_q != '0) begin
         byte_cnt_d = byte_cnt_q - CW'(1);
         for (int k = 0; k < BYTES; k++) begin
            if (byte_cnt_d == CW'(k)) tx_data_d = pkt_q[k*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_q      <= '0;
         gnt_id_q   <= '0;
         rr_ptr_q   <= '0;
         byte_cnt_q <= '0;
         tx_data_q  <= 8'h00;
      end else begin
         pkt_q      <= pkt_d;
         gnt_id_q   <= gnt_id_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.trmt    = trmt_c;
   assign bus.busy    = busy_c;
   assign bus.ack     = ack_c;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.tx_data = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a UART model answers trmt with a delayed tx_done,
// and a queue-based round-robin model predicts ack order and byte stream.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int B  = 2;
   localparam int PW = 8 * B;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if #(.NUM_REQ(N), .BYTES(B)) bus ();
   uart_tx_arbiter #(.NUM_REQ(N), .BYTES(B)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART model: tx_done drops after a trmt, rises d cycles later, and stays high.
   int dly_min = 1;
   int dly_max = 3;
   bit uart_stuck = 1'b0;
   initial begin : uart_model
      int   ucnt;
      logic t, r;
      ucnt = -1;
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         t = bus.trmt;
         r = rst;
         @(posedge clk);
         #1;
         if (r) begin
            bus.tx_done = 1'b0;
            ucnt = -1;
         end else if (t === 1'b1) begin
            bus.tx_done = 1'b0;
            ucnt = int'($urandom_range(dly_max, dly_min));
         end else if (ucnt > 0) begin
            if (!uart_stuck) ucnt--;
            if (ucnt == 0) begin
               bus.tx_done = 1'b1;
               ucnt = -1;
            end
         end
      end
   end

   logic [7:0]    byte_log [$];
   int            trmt_cyc [$];
   int            ack_log  [$];
   int            ack_cyc  [$];
   int            busy_viol = 0;
   int            ack_viol  = 0;
   bit            drop_on_ack = 1'b1;

   int            rr_model = 0;
   logic [PW-1:0] pkt [N];
   int            exp_ack   [$];
   logic [7:0]    exp_bytes [$];

   function automatic int rr_pick(input logic [N-1:0] m, input int rr);
      for (int k = 0; k < N; k++) begin
         if (m[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [7:0] byte_of(input logic [PW-1:0] p, input int j);
      logic [PW-1:0] s;
      s = p >> (8 * j);
      return s[7:0];
   endfunction

   // Requesters in mask are all pending at once; serve them one packet each in rr order.
   task automatic model_serve(input logic [N-1:0] mask);
      logic [N-1:0] m;
      int w;
      m = mask;
      while (m != '0) begin
         w = rr_pick(m, rr_model);
         exp_ack.push_back(w);
         for (int j = B - 1; j >= 0; j--) exp_bytes.push_back(byte_of(pkt[w], j));
         m[w] = 1'b0;
         rr_model = (w + 1) % N;
      end
   endtask

   task automatic set_pkt(input int i, input logic [PW-1:0] v);
      pkt[i] = v;
      bus.pkt_data[i*PW +: PW] = v;
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus.trmt === 1'b1) begin
         byte_log.push_back(bus.tx_data);
         trmt_cyc.push_back(cyc);
         if (bus.busy !== 1'b1) busy_viol++;
      end
      if (bus.ack !== '0) begin
         if ($countones(bus.ack) != 1 || bus.busy !== 1'b1 || bus.ack[bus.gnt_id] !== 1'b1)
            ack_viol++;
         for (int i = 0; i < N; i++) if (bus.ack[i] === 1'b1) ack_log.push_back(i);
         ack_cyc.push_back(cyc);
         if (drop_on_ack) bus.req = bus.req & ~bus.ack;
      end
   endtask

   task automatic clear_logs();
      byte_log.delete();
      trmt_cyc.delete();
      ack_log.delete();
      ack_cyc.delete();
      exp_ack.delete();
      exp_bytes.delete();
      busy_viol = 0;
      ack_viol  = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.req = '0;
      repeat (3) tick();
      rst = 1'b0;
      rr_model = 0;
      tick();
      clear_logs();
   endtask

   task automatic run_until(input int n, input int budget, output bit late);
      int c;
      c = 0;
      while (ack_log.size() < n && c < budget) begin
         tick();
         c++;
      end
      late = (ack_log.size() < n);
   endtask

   task automatic test_reset();
      bus.req = 4'b1111;
      for (int i = 0; i < N; i++) set_pkt(i, PW'($urandom));
      tick();
      tick();
      n_cmp++; if (bus.trmt !== 1'b0) begin n_bad++; $display("FAIL reset_trmt: got %b want 0", bus.trmt); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
      n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
      n_cmp++; if (bus.gnt_id !== 2'd0) begin n_bad++; $display("FAIL reset_gnt_id: got %0d want 0", bus.gnt_id); end
      bus.req = '0;
      rst = 1'b0;
      repeat (3) tick();
      n_cmp++; if (bus.busy !== 1'b0 || trmt_cyc.size() != 0) begin
         n_bad++; $display("FAIL idle_no_req: got busy=%b trmts=%0d want 0/0", bus.busy, trmt_cyc.size());
      end
      rr_model = 0;
      clear_logs();
   endtask

   task automatic test_single();
      bit late;
      int c0;
      dly_min = 20; dly_max = 20;
      set_pkt(0, 16'hA55A);
      model_serve(4'b0001);
      c0 = cyc;
      bus.req = 4'b0001;
      run_until(1, 200, late);
      repeat (4) tick();
      n_cmp++; if (late) begin n_bad++; $display("FAIL single_timeout: got no ack want ack"); end
      n_cmp++; if (byte_log.size() != 2) begin n_bad++; $display("FAIL single_trmt_count: got %0d want 2", byte_log.size()); end
      if (byte_log.size() == 2) begin
         n_cmp++; if (byte_log[0] !== 8'hA5) begin n_bad++; $display("FAIL single_byte0: got %h want a5", byte_log[0]); end
         n_cmp++; if (byte_log[1] !== 8'h5A) begin n_bad++; $display("FAIL single_byte1: got %h want 5a", byte_log[1]); end
         n_cmp++; if (trmt_cyc[0] != c0 + 1) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", trmt_cyc[0] - c0, 1); end
         n_cmp++; if (trmt_cyc[1] - trmt_cyc[0] != 22) begin n_bad++; $display("FAIL single_byte_gap: got %0d want 22", trmt_cyc[1] - trmt_cyc[0]); end
      end
      n_cmp++; if (ack_log.size() != 1 || (ack_log.size() > 0 && ack_log[0] != 0)) begin
         n_bad++; $display("FAIL single_ack: got count %0d want one ack[0]", ack_log.size());
      end
      if (ack_cyc.size() == 1 && trmt_cyc.size() == 2) begin
         n_cmp++; if (ack_cyc[0] - trmt_cyc[1] != 22) begin n_bad++; $display("FAIL single_ack_latency: got %0d want 22", ack_cyc[0] - trmt_cyc[1]); end
      end
      clear_logs();
   endtask

   task automatic test_round_robin();
      bit late;
      apply_reset();
      dly_min = 1; dly_max = 4;
      for (int i = 0; i < N; i++) set_pkt(i, PW'($urandom));
      model_serve(4'b1111);
      bus.req = 4'b1111;
      run_until(4, 200, late);
      repeat (4) tick();
      n_cmp++; if (late || ack_log.size() != 4) begin n_bad++; $display("FAIL rr_ack_count: got %0d want 4", ack_log.size()); end
      for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++) begin
         n_cmp++; if (ack_log[i] != exp_ack[i]) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ack_log[i], exp_ack[i]); end
      end
      for (int i = 0; i < exp_bytes.size() && i < byte_log.size(); i++) begin
         n_cmp++; if (byte_log[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL rr_byte[%0d]: got %h want %h", i, byte_log[i], exp_bytes[i]); end
      end
      for (int k = 1; k < 4 && k * B < trmt_cyc.size() && k <= ack_cyc.size(); k++) begin
         n_cmp++; if (trmt_cyc[k*B] - ack_cyc[k-1] != 2) begin
            n_bad++; $display("FAIL rr_regrant_gap[%0d]: got %0d want 2", k, trmt_cyc[k*B] - ack_cyc[k-1]);
         end
      end
      n_cmp++; if (busy_viol != 0 || ack_viol != 0) begin n_bad++; $display("FAIL rr_busy_ack: got %0d/%0d violations want 0/0", busy_viol, ack_viol); end
      clear_logs();
   endtask

   task automatic test_wrap();
      bit late;
      set_pkt(0, PW'($urandom));
      set_pkt(3, PW'($urandom));
      model_serve(4'b1001);
      bus.req = 4'b1001;
      run_until(2, 120, late);
      repeat (4) tick();
      n_cmp++; if (late || ack_log.size() != 2) begin n_bad++; $display("FAIL wrap_ack_count: got %0d want 2", ack_log.size()); end
      for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++) begin
         n_cmp++; if (ack_log[i] != exp_ack[i]) begin n_bad++; $display("FAIL wrap_order[%0d]: got %0d want %0d", i, ack_log[i], exp_ack[i]); end
      end
      clear_logs();
   endtask

   task automatic test_done_held();
      bit late;
      dly_min = 1; dly_max = 1;
      set_pkt(2, PW'($urandom));
      model_serve(4'b0100);
      bus.req = 4'b0100;
      run_until(1, 60, late);
      repeat (4) tick();
      n_cmp++; if (byte_log.size() != 2) begin n_bad++; $display("FAIL held_trmt_count: got %0d want 2", byte_log.size()); end
      if (trmt_cyc.size() == 2 && ack_cyc.size() == 1) begin
         n_cmp++; if (trmt_cyc[1] - trmt_cyc[0] != 3) begin n_bad++; $display("FAIL held_byte_gap: got %0d want 3", trmt_cyc[1] - trmt_cyc[0]); end
         n_cmp++; if (ack_cyc[0] - trmt_cyc[1] != 3) begin n_bad++; $display("FAIL held_ack_gap: got %0d want 3", ack_cyc[0] - trmt_cyc[1]); end
      end
      for (int i = 0; i < exp_bytes.size() && i < byte_log.size(); i++) begin
         n_cmp++; if (byte_log[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL held_byte[%0d]: got %h want %h", i, byte_log[i], exp_bytes[i]); end
      end
      clear_logs();
   endtask

   task automatic test_no_preempt();
      bit late;
      dly_min = 5; dly_max = 5;
      set_pkt(1, PW'($urandom));
      model_serve(4'b0010);
      bus.req = 4'b0010;
      for (int c = 0; c < 30 && trmt_cyc.size() == 0; c++) tick();
      repeat (2) tick();
      set_pkt(1, PW'($urandom));
      set_pkt(0, PW'($urandom));
      model_serve(4'b0001);
      bus.req = bus.req | 4'b0001;
      run_until(2, 120, late);
      repeat (4) tick();
      n_cmp++; if (late || ack_log.size() != 2) begin n_bad++; $display("FAIL nopre_ack_count: got %0d want 2", ack_log.size()); end
      for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++) begin
         n_cmp++; if (ack_log[i] != exp_ack[i]) begin n_bad++; $display("FAIL nopre_order[%0d]: got %0d want %0d", i, ack_log[i], exp_ack[i]); end
      end
      for (int i = 0; i < exp_bytes.size() && i < byte_log.size(); i++) begin
         n_cmp++; if (byte_log[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL nopre_byte[%0d]: got %h want %h", i, byte_log[i], exp_bytes[i]); end
      end
      if (trmt_cyc.size() > B && ack_cyc.size() > 0) begin
         n_cmp++; if (trmt_cyc[B] - ack_cyc[0] != 2) begin n_bad++; $display("FAIL nopre_gap: got %0d want 2", trmt_cyc[B] - ack_cyc[0]); end
      end
      clear_logs();
   endtask

   task automatic test_drop_after_grant();
      bit late;
      dly_min = 2; dly_max = 4;
      set_pkt(3, PW'($urandom));
      model_serve(4'b1000);
      bus.req = 4'b1000;
      for (int c = 0; c < 30 && trmt_cyc.size() == 0; c++) tick();
      bus.req = '0;
      run_until(1, 60, late);
      repeat (4) tick();
      n_cmp++; if (late || ack_log.size() != 1 || ack_log[0] != exp_ack[0]) begin
         n_bad++; $display("FAIL dropgnt_ack: got count %0d want one ack[%0d]", ack_log.size(), exp_ack[0]);
      end
      n_cmp++; if (byte_log.size() != B) begin n_bad++; $display("FAIL dropgnt_bytes: got %0d want %0d", byte_log.size(), B); end
      n_cmp++; if (bus.gnt_id !== 2'd3 || bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL dropgnt_idle: got gnt=%0d busy=%b want 3/0", bus.gnt_id, bus.busy);
      end
      clear_logs();
   endtask

   task automatic test_held_after_ack();
      bit late;
      drop_on_ack = 1'b0;
      set_pkt(2, PW'($urandom));
      model_serve(4'b0100);
      model_serve(4'b0100);
      bus.req = 4'b0100;
      run_until(2, 120, late);
      bus.req = '0;
      drop_on_ack = 1'b1;
      repeat (6) tick();
      n_cmp++; if (ack_log.size() != 2) begin n_bad++; $display("FAIL reheld_ack_count: got %0d want 2", ack_log.size()); end
      for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++) begin
         n_cmp++; if (ack_log[i] != exp_ack[i]) begin n_bad++; $display("FAIL reheld_order[%0d]: got %0d want %0d", i, ack_log[i], exp_ack[i]); end
      end
      clear_logs();
   endtask

   task automatic test_stuck_and_drop();
      bit late;
      dly_min = 2; dly_max = 2;
      uart_stuck = 1'b1;
      set_pkt(0, PW'($urandom));
      set_pkt(2, PW'($urandom));
      model_serve(4'b0001);
      bus.req = 4'b0001;
      repeat (20) tick();
      bus.req = bus.req | 4'b0100;
      repeat (20) tick();
      bus.req = bus.req & 4'b1011;
      repeat (20) tick();
      n_cmp++; if (byte_log.size() != 1 || ack_log.size() != 0 || bus.busy !== 1'b1) begin
         n_bad++; $display("FAIL stuck_hold: got trmts=%0d acks=%0d busy=%b want 1/0/1", byte_log.size(), ack_log.size(), bus.busy);
      end
      uart_stuck = 1'b0;
      run_until(1, 60, late);
      repeat (8) tick();
      n_cmp++; if (ack_log.size() != 1 || ack_log[0] != exp_ack[0]) begin
         n_bad++; $display("FAIL stuck_release_ack: got count %0d want one ack[%0d]", ack_log.size(), exp_ack[0]);
      end
      n_cmp++; if (byte_log.size() != B) begin n_bad++; $display("FAIL dropped_req_served: got %0d trmts want %0d", byte_log.size(), B); end
      clear_logs();
   endtask

   task automatic test_reset_mid();
      bit late;
      dly_min = 10; dly_max = 10;
      set_pkt(3, PW'($urandom));
      bus.req = 4'b1000;
      for (int c = 0; c < 30 && trmt_cyc.size() == 0; c++) tick();
      repeat (2) tick();
      rst = 1'b1;
      bus.req = '0;
      tick();
      n_cmp++; if (bus.trmt !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
         n_bad++; $display("FAIL rstmid_outputs: got trmt=%b busy=%b ack=%b want 0/0/0000", bus.trmt, bus.busy, bus.ack);
      end
      rst = 1'b0;
      rr_model = 0;
      clear_logs();
      set_pkt(1, PW'($urandom));
      set_pkt(2, PW'($urandom));
      model_serve(4'b0110);
      bus.req = 4'b0110;
      dly_min = 1; dly_max = 3;
      run_until(2, 100, late);
      repeat (4) tick();
      n_cmp++; if (late || ack_log.size() != 2) begin n_bad++; $display("FAIL rstmid_ack_count: got %0d want 2", ack_log.size()); end
      for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++) begin
         n_cmp++; if (ack_log[i] != exp_ack[i]) begin n_bad++; $display("FAIL rstmid_order[%0d]: got %0d want %0d", i, ack_log[i], exp_ack[i]); end
      end
      clear_logs();
   endtask

   task automatic test_random();
      bit late;
      logic [N-1:0] mask;
      dly_min = 1; dly_max = 6;
      for (int it = 0; it < 20; it++) begin
         mask = N'($urandom_range(15, 1));
         for (int i = 0; i < N; i++) set_pkt(i, PW'($urandom));
         model_serve(mask);
         bus.req = mask;
         run_until(exp_ack.size(), 40 * N, late);
         repeat (4) tick();
         n_cmp++; if (ack_log.size() != exp_ack.size()) begin
            n_bad++; $display("FAIL rand%0d_ack_count: got %0d want %0d", it, ack_log.size(), exp_ack.size());
         end
         for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++) begin
            n_cmp++; if (ack_log[i] != exp_ack[i]) begin n_bad++; $display("FAIL rand%0d_order[%0d]: got %0d want %0d", it, i, ack_log[i], exp_ack[i]); end
         end
         n_cmp++; if (byte_log.size() != exp_bytes.size()) begin
            n_bad++; $display("FAIL rand%0d_byte_count: got %0d want %0d", it, byte_log.size(), exp_bytes.size());
         end
         for (int i = 0; i < exp_bytes.size() && i < byte_log.size(); i++) begin
            n_cmp++; if (byte_log[i] !== exp_bytes[i]) begin n_bad++; $display("FAIL rand%0d_byte[%0d]: got %h want %h", it, i, byte_log[i], exp_bytes[i]); end
         end
         n_cmp++; if (busy_viol != 0 || ack_viol != 0) begin
            n_bad++; $display("FAIL rand%0d_busy_ack: got %0d/%0d violations want 0/0", it, busy_viol, ack_viol);
         end
         clear_logs();
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req = '0;
      bus.pkt_data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_done_held();
      test_no_preempt();
      test_drop_after_grant();
      test_held_after_ack();
      test_stuck_and_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
